opram_sequencer: RTL and testbench

OPRAM_SEQUENCER -- requirements
Module: opram_sequencer

---
 rtl/opram_pkg.sv | 16 +
 rtl/opram_mem.sv | 23 ++
 rtl/opram_sequencer.sv | 144 ++++++++++++++
 tb/tb_opram_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/opram_pkg.sv
// Shared state encoding for the op-RAM sequencer.
package opram_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ENC_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ENC_LOAD = 2'd1;
   localparam logic [STATE_W-1:0] ENC_RUN  = 2'd2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = ENC_IDLE,
      ST_LOAD = ENC_LOAD,
      ST_RUN  = ENC_RUN
   } state_t;

endpackage

// File: rtl/opram_mem.sv
// Op storage: one write port, one registered read port.
// The read register only updates on rd_en, so a stalled consumer sees a stable word.
module opram_mem #(
   parameter int OP_W   = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [OP_W-1:0]   wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [OP_W-1:0]   rd_data
);

   logic [OP_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/opram_sequencer.sv
// Loads a short op program into RAM, then plays it out over a valid/ready port.
//   state   | meaning
//   IDLE    | program held, waiting for load_start or run
//   LOAD    | accepting op words into RAM at wptr
//   RUN     | fetching and presenting ops at pc
module opram_sequencer
   import opram_pkg::*;
#(
   parameter int OP_W   = 8,
   parameter int ADDR_W = 4,
   parameter int LOOP   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [OP_W-1:0]   load_op,
   input  logic              load_done,
   output logic              load_ready,
   input  logic              run,
   input  logic              stop,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [OP_W-1:0]   op,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W:0]   prog_len,
   output logic              busy,
   output logic              err
);

   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] wptr, wptr_nxt, pc_nxt, inc_pc, rd_addr;
   logic [ADDR_W:0]   len_nxt;
   logic              valid_nxt, err_nxt;
   logic              wr_en, rd_en, at_last, jump_ok;
   logic [OP_W-1:0]   rd_data;

   opram_mem #(.OP_W(OP_W), .ADDR_W(ADDR_W)) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wptr),
      .wr_data (load_op),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign at_last = ({1'b0, pc} == (prog_len - 1'b1));
   assign inc_pc  = at_last ? '0 : pc + 1'b1;
   assign jump_ok = ({1'b0, jump_addr} < prog_len);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         pc       <= '0;
         wptr     <= '0;
         prog_len <= '0;
         op_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         wptr     <= wptr_nxt;
         prog_len <= len_nxt;
         op_valid <= valid_nxt;
         err      <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      wptr_nxt  = wptr;
      len_nxt   = prog_len;
      valid_nxt = op_valid;
      err_nxt   = err;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      rd_addr   = pc;
      unique case (state)
         ST_IDLE: begin
            if (load_start) begin
               state_nxt = ST_LOAD;
               wptr_nxt  = '0;
               len_nxt   = '0;
               err_nxt   = 1'b0;
            end else if (run) begin
               if (prog_len == '0) begin
                  err_nxt = 1'b1;
               end else begin
                  state_nxt = ST_RUN;
                  pc_nxt    = '0;
                  valid_nxt = 1'b0;
               end
            end
         end
         ST_LOAD: begin
            // A word arriving with load_done is still stored.
            if (load_valid) begin
               wr_en    = 1'b1;
               wptr_nxt = wptr + 1'b1;
               len_nxt  = prog_len + 1'b1;
               if (len_nxt == FULL) state_nxt = ST_IDLE;
            end
            if (load_done) state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            if (stop) begin
               state_nxt = ST_IDLE;
               valid_nxt = 1'b0;
            end else if (jump && jump_ok) begin
               // Target is read on the following cycle, leaving one bubble.
               pc_nxt    = jump_addr;
               valid_nxt = 1'b0;
            end else begin
               if (jump) err_nxt = 1'b1;
               if (!op_valid) begin
                  rd_en     = 1'b1;
                  valid_nxt = 1'b1;
               end else if (op_ready) begin
                  if (at_last && LOOP == 0) begin
                     state_nxt = ST_IDLE;
                     valid_nxt = 1'b0;
                  end else begin
                     pc_nxt  = inc_pc;
                     rd_en   = 1'b1;
                     rd_addr = inc_pc;
                  end
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign op         = op_valid ? rd_data : '0;
   assign load_ready = (state == ST_LOAD);
   assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_opram_sequencer.sv
// Bench for opram_sequencer: a looping and a stop-at-end instance share stimulus
// and are checked every cycle against a program-level model.
module tb_opram_sequencer;

   localparam int OP_W   = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic load_start = 0, load_valid = 0, load_done = 0, run = 0, stop = 0, jump = 0, op_ready = 0;
   logic [OP_W-1:0]   load_op = '0;
   logic [ADDR_W-1:0] jump_addr = '0;

   logic [OP_W-1:0]   op_l, op_s;
   logic              valid_l, valid_s, busy_l, busy_s, err_l, err_s, lr_l, lr_s;
   logic [ADDR_W-1:0] pc_l, pc_s;
   logic [ADDR_W:0]   len_l, len_s;

   int n_checks = 0;
   int n_pass   = 0;

   // index 1 = LOOP=1 instance, index 0 = LOOP=0 instance
   int m_state [2];
   int m_pc    [2];
   int m_valid [2];
   int m_len   [2];
   int m_err   [2];
   int m_mem   [2][DEPTH];

   logic [7:0] exp_seq [5];
   logic [7:0] words [DEPTH+2];

   always #5 clk = ~clk;

   opram_sequencer #(.OP_W(OP_W), .ADDR_W(ADDR_W), .LOOP(1)) dut_loop (
      .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid), .load_op(load_op),
      .load_done(load_done), .load_ready(lr_l), .run(run), .stop(stop), .jump(jump),
      .jump_addr(jump_addr), .op(op_l), .op_valid(valid_l), .op_ready(op_ready), .pc(pc_l),
      .prog_len(len_l), .busy(busy_l), .err(err_l));

   opram_sequencer #(.OP_W(OP_W), .ADDR_W(ADDR_W), .LOOP(0)) dut_stop (
      .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid), .load_op(load_op),
      .load_done(load_done), .load_ready(lr_s), .run(run), .stop(stop), .jump(jump),
      .jump_addr(jump_addr), .op(op_s), .op_valid(valid_s), .op_ready(op_ready), .pc(pc_s),
      .prog_len(len_s), .busy(busy_s), .err(err_s));

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   task automatic model_reset(input int k);
      m_state[k] = M_IDLE;
      m_pc[k]    = 0;
      m_valid[k] = 0;
      m_len[k]   = 0;
      m_err[k]   = 0;
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            model_reset(k);
         end else if (m_state[k] == M_IDLE) begin
            if (load_start) begin
               m_state[k] = M_LOAD;
               m_len[k]   = 0;
               m_err[k]   = 0;
            end else if (run) begin
               if (m_len[k] == 0) m_err[k] = 1;
               else begin
                  m_state[k] = M_RUN;
                  m_pc[k]    = 0;
                  m_valid[k] = 0;
               end
            end
         end else if (m_state[k] == M_LOAD) begin
            if (load_valid) begin
               m_mem[k][m_len[k]] = int'(load_op);
               m_len[k]++;
               if (m_len[k] == DEPTH) m_state[k] = M_IDLE;
            end
            if (load_done) m_state[k] = M_IDLE;
         end else begin
            if (stop) begin
               m_state[k] = M_IDLE;
               m_valid[k] = 0;
            end else if (jump && int'(jump_addr) < m_len[k]) begin
               m_pc[k]    = int'(jump_addr);
               m_valid[k] = 0;
            end else begin
               if (jump) m_err[k] = 1;
               if (m_valid[k] == 0) m_valid[k] = 1;
               else if (op_ready) begin
                  if (m_pc[k] == m_len[k] - 1) begin
                     if (k == 1) m_pc[k] = 0;
                     else begin
                        m_state[k] = M_IDLE;
                        m_valid[k] = 0;
                     end
                  end else begin
                     m_pc[k]++;
                  end
               end
            end
         end
      end
   endtask

   task automatic cmp_inst(input int k, input logic [OP_W-1:0] o, input logic v,
                           input logic [ADDR_W-1:0] p, input logic [ADDR_W:0] l,
                           input logic b, input logic e, input logic lr);
      chk($sformatf("op_valid[%0d]", k), int'(v), m_valid[k]);
      chk($sformatf("pc[%0d]", k), int'(p), m_pc[k]);
      chk($sformatf("prog_len[%0d]", k), int'(l), m_len[k]);
      chk($sformatf("busy[%0d]", k), int'(b), int'(m_state[k] != M_IDLE));
      chk($sformatf("err[%0d]", k), int'(e), m_err[k]);
      chk($sformatf("load_ready[%0d]", k), int'(lr), int'(m_state[k] == M_LOAD));
      if (m_valid[k] != 0) chk($sformatf("op[%0d]", k), int'(o), m_mem[k][m_pc[k]]);
   endtask

   always @(negedge clk) begin
      cmp_inst(1, op_l, valid_l, pc_l, len_l, busy_l, err_l, lr_l);
      cmp_inst(0, op_s, valid_s, pc_s, len_s, busy_s, err_s, lr_s);
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      model_reset(0);
      model_reset(1);
      repeat (2) @(negedge clk);
      #1;
      chk("reset_busy", int'(busy_l), 0);
      chk("reset_len", int'(len_l), 0);
      chk("reset_valid", int'(valid_l), 0);
      chk("reset_err", int'(err_s), 0);
      rst = 1'b0;

      // load 11,22,33 with done on the last word, then free-running consume
      load_start = 1; tick(); load_start = 0;
      load_valid = 1; load_op = 8'h11; tick();
      load_op = 8'h22; tick();
      load_op = 8'h33; load_done = 1; tick();
      load_valid = 0; load_done = 0;
      chk("load3_len_l", int'(len_l), 3);
      chk("load3_len_s", int'(len_s), 3);
      run = 1; op_ready = 1; tick(); run = 0;
      chk("run_t1_pc", int'(pc_l), 0);
      chk("run_t1_valid", int'(valid_l), 0);
      tick();
      exp_seq = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};
      for (int i = 0; i < 5; i++) begin
         chk("loop_op", int'(op_l), int'(exp_seq[i]));
         chk("loop_valid", int'(valid_l), 1);
         if (i < 3) chk("stopmode_op", int'(op_s), int'(exp_seq[i]));
         if (i == 3) begin
            chk("stopmode_valid_end", int'(valid_s), 0);
            chk("stopmode_busy_end", int'(busy_s), 0);
         end
         tick();
      end
      stop = 1; op_ready = 0; tick(); stop = 0;
      chk("stop_busy", int'(busy_l), 0);

      // backpressure at pc=1
      run = 1; op_ready = 1; tick(); run = 0; tick(); tick();
      op_ready = 0;
      for (int i = 0; i < 3; i++) begin
         chk("hold_op", int'(op_l), 8'h22);
         chk("hold_pc", int'(pc_l), 1);
         chk("hold_op_s", int'(op_s), 8'h22);
         tick();
      end
      op_ready = 1; tick();
      chk("resume_op", int'(op_l), 8'h33);
      chk("resume_pc", int'(pc_l), 2);
      stop = 1; op_ready = 0; tick(); stop = 0;

      // valid jump at pc=0, then out-of-range jump with a handshake
      run = 1; tick(); run = 0; tick();
      jump = 1; jump_addr = 4'd2; tick(); jump = 0;
      chk("jump_bubble", int'(valid_l), 0);
      chk("jump_pc", int'(pc_l), 2);
      tick();
      chk("jump_op", int'(op_l), 8'h33);
      chk("jump_valid", int'(valid_l), 1);
      jump = 1; jump_addr = 4'd5; op_ready = 1; tick(); jump = 0; op_ready = 0;
      chk("badjump_err_l", int'(err_l), 1);
      chk("badjump_err_s", int'(err_s), 1);
      chk("badjump_cont_op", int'(op_l), 8'h11);
      chk("badjump_cont_valid", int'(valid_l), 1);
      stop = 1; tick(); stop = 0;

      // overfull load: DEPTH+2 words, the last two must be dropped
      for (int i = 0; i < DEPTH + 2; i++) words[i] = 8'($urandom_range(0, 255));
      words[DEPTH]   = ~words[0];
      words[DEPTH+1] = ~words[1];
      load_start = 1; tick(); load_start = 0;
      chk("reload_err_clear", int'(err_l), 0);
      load_valid = 1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         load_op = words[i];
         tick();
         if (i == DEPTH - 1) begin
            chk("full_len", int'(len_l), DEPTH);
            chk("full_auto_idle", int'(busy_l), 0);
         end
      end
      load_valid = 0;
      chk("full_len_after", int'(len_l), DEPTH);
      run = 1; op_ready = 1; tick(); run = 0; tick();
      chk("full_op0", int'(op_l), int'(words[0]));
      repeat (DEPTH - 1) tick();
      chk("full_op15", int'(op_l), int'(words[DEPTH-1]));
      tick();
      chk("full_wrap_op0", int'(op_l), int'(words[0]));
      tick();
      chk("full_wrap_op1", int'(op_l), int'(words[1]));
      stop = 1; op_ready = 0; tick(); stop = 0;

      // reset while an op is presented
      run = 1; tick(); run = 0; tick();
      chk("pre_rst_valid", int'(valid_l), 1);
      #1;
      rst = 1;
      model_reset(0);
      model_reset(1);
      #1;
      chk("async_rst_valid", int'(valid_l), 0);
      chk("async_rst_busy", int'(busy_l), 0);
      chk("async_rst_len", int'(len_l), 0);
      chk("async_rst_valid_s", int'(valid_s), 0);
      #1;
      rst = 0;
      run = 1; tick(); run = 0;
      chk("run_after_rst_err", int'(err_l), 1);
      chk("run_after_rst_busy", int'(busy_l), 0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 399) == 0);
         if (rst) begin
            model_reset(0);
            model_reset(1);
         end
         load_start = ($urandom_range(0, 49) == 0);
         load_valid = $urandom_range(0, 1) == 1;
         load_op    = 8'($urandom);
         load_done  = ($urandom_range(0, 15) == 0);
         run        = ($urandom_range(0, 9) == 0);
         stop       = ($urandom_range(0, 39) == 0);
         jump       = ($urandom_range(0, 11) == 0);
         jump_addr  = 4'($urandom);
         op_ready   = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
